// File: rtl/pll_lock_rst_sequencer_pkg.sv
// ============================================================================
// Module : pll_seq_pkg
// Brief  : Shared FSM state type, counter sizing and parameter limits for
//          the PLL lock / reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } pll_seq_state_t;

    localparam int c_min_ch     = 1;
    localparam int c_max_ch     = 16;
    localparam int c_min_cycles = 1;

    // Wide enough to hold the limit itself, so no counter can ever wrap.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_rst_sequencer_sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Single-bit two-flop synchroniser, asynchronous reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pll_lock_rst_sequencer.sv
// ============================================================================
// Module : pll_lock_rst_sequencer
// Brief  : Pulses the PLL reset, waits for stable lock on all channels, then
//          releases per-domain resets in index order; restarts on lock loss.
//          Optional WAIT_LOCK watchdog: define PLL_LOCK_WDT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_lock_rst_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP        = 8,
    parameter int CNT_W              = 8,
    parameter int LOCK_TIMEOUT       = 65536
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] locked_in,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_ready,
    output logic [CNT_W-1:0]  lock_loss_cnt
);

    localparam int c_lim_a   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_cnt_lim = (c_lim_a > RELEASE_GAP) ? c_lim_a : RELEASE_GAP;
    localparam int c_cnt_w   = cnt_width(c_cnt_lim);
    localparam int c_idx_w   = cnt_width(NUM_CH);

    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last    = c_cnt_w'(RELEASE_GAP - 1);
    localparam logic [c_idx_w-1:0] c_last_idx    = c_idx_w'(NUM_CH - 1);

    generate
        if (NUM_CH < c_min_ch || NUM_CH > c_max_ch || PLL_RST_CYCLES < c_min_cycles ||
            LOCK_STABLE_CYCLES < c_min_cycles || RELEASE_GAP < c_min_cycles ||
            LOCK_TIMEOUT < c_min_cycles || CNT_W < 1) begin : g_bad_params
            $error("pll_lock_rst_sequencer: illegal parameter value");
        end
    endgenerate

    logic [NUM_CH-1:0]  w_lock_sync;
    logic               w_lock_all;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
            sync_2ff u_sync (
                .clk (refclk),
                .rst (rst),
                .i_d (locked_in[g]),
                .o_q (w_lock_sync[g])
            );
        end
    endgenerate

    assign w_lock_all = &w_lock_sync;

    pll_seq_state_t     r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [c_idx_w-1:0] r_idx, w_idx_nxt;
    logic [NUM_CH-1:0]  w_ch_rst_nxt;
    logic [CNT_W-1:0]   w_loss_nxt;
    logic               w_lock_lost;

`ifdef PLL_LOCK_WDT_EN
    localparam int                 c_wdt_w    = cnt_width(LOCK_TIMEOUT);
    localparam logic [c_wdt_w-1:0] c_wdt_last = c_wdt_w'(LOCK_TIMEOUT - 1);
    logic [c_wdt_w-1:0] r_wdt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_loss_nxt  = lock_loss_cnt;
        w_lock_lost = 1'b0;

        case (r_state)
            PLL_RST: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (!w_lock_all) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`ifdef PLL_LOCK_WDT_EN
                if (r_wdt == c_wdt_last) begin
                    w_lock_lost = 1'b1;
                end
`endif
            end
            RELEASE: begin
                // Lock loss outranks any release step in the same cycle.
                if (!w_lock_all) begin
                    w_lock_lost = 1'b1;
                end else if (r_idx == c_last_idx) begin
                    w_state_nxt = RUN;
                end else if (r_cnt == c_gap_last) begin
                    w_idx_nxt = r_idx + 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_lock_all) begin
                    w_lock_lost = 1'b1;
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_lock_lost) begin
            w_state_nxt = PLL_RST;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            if (lock_loss_cnt != {CNT_W{1'b1}}) begin
                w_loss_nxt = lock_loss_cnt + 1'b1;
            end
        end

        // Channels 0..idx are released while releasing or running.
        w_ch_rst_nxt = '1;
        if (w_state_nxt == RELEASE || w_state_nxt == RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                w_ch_rst_nxt[i] = (c_idx_w'(i) > w_idx_nxt);
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state       <= PLL_RST;
            r_cnt         <= '0;
            r_idx         <= '0;
            pll_rst       <= 1'b1;
            ch_rst        <= '1;
            all_ready     <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            pll_rst       <= (w_state_nxt == PLL_RST);
            ch_rst        <= w_ch_rst_nxt;
            all_ready     <= (w_state_nxt == RUN);
            lock_loss_cnt <= w_loss_nxt;
        end
    end

`ifdef PLL_LOCK_WDT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_wdt <= '0;
        end else if (r_state == WAIT_LOCK && w_state_nxt == WAIT_LOCK) begin
            r_wdt <= r_wdt + 1'b1;
        end else begin
            r_wdt <= '0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_rst_sequencer.sv
// ============================================================================
// Module : tb_pll_lock_rst_sequencer
// Brief  : Directed self-checking bench for pll_lock_rst_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_rst_sequencer;

    localparam int NUM_CH             = 2;
    localparam int PLL_RST_CYCLES     = 16;
    localparam int LOCK_STABLE_CYCLES = 1024;
    localparam int RELEASE_GAP        = 8;
    localparam int CNT_W              = 2;
    localparam int LOCK_TIMEOUT       = 65536;

    logic              refclk    = 1'b0;
    logic              rst       = 1'b1;
    logic [NUM_CH-1:0] locked_in = 2'b11;
    logic              pll_rst;
    logic [NUM_CH-1:0] ch_rst;
    logic              all_ready;
    logic [CNT_W-1:0]  lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 refclk = ~refclk;

    pll_lock_rst_sequencer #(
        .NUM_CH             (NUM_CH),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .RELEASE_GAP        (RELEASE_GAP),
        .CNT_W              (CNT_W),
        .LOCK_TIMEOUT       (LOCK_TIMEOUT)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .locked_in     (locked_in),
        .pll_rst       (pll_rst),
        .ch_rst        (ch_rst),
        .all_ready     (all_ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drop lock in RELEASE/RUN, check the restart, re-lock and reach the first release.
    task automatic lose_and_relock(input logic [31:0] exp_cnt);
        locked_in = 2'b10;
        tick(3);
        chk("sat_loss_cnt", 32'(lock_loss_cnt), exp_cnt);
        chk("sat_ch_rst", 32'(ch_rst), 32'h3);
        chk("sat_pll_rst", 32'(pll_rst), 32'h1);
        locked_in = 2'b11;
        tick(16);
        chk("sat_pll_rst_low", 32'(pll_rst), 32'h0);
        tick(1024);
        chk("sat_release0", 32'(ch_rst), 32'h2);
    endtask

    initial begin
        // Reset state while rst is held.
        #12;
        chk("rst_pll_rst", 32'(pll_rst), 32'h1);
        chk("rst_ch_rst", 32'(ch_rst), 32'h3);
        chk("rst_all_ready", 32'(all_ready), 32'h0);
        chk("rst_loss_cnt", 32'(lock_loss_cnt), 32'h0);
        @(negedge refclk);
        rst = 1'b0;

        // Power-up sequence, locks held.
        tick(15);
        chk("pu_pll_rst_15", 32'(pll_rst), 32'h1);
        tick(1);
        chk("pu_pll_rst_16", 32'(pll_rst), 32'h0);
        chk("pu_ch_rst_16", 32'(ch_rst), 32'h3);
        tick(1023);
        chk("pu_ch_rst_1039", 32'(ch_rst), 32'h3);
        tick(1);
        chk("pu_ch_rst_1040", 32'(ch_rst), 32'h2);
        chk("pu_ready_1040", 32'(all_ready), 32'h0);
        tick(7);
        chk("pu_ch_rst_1047", 32'(ch_rst), 32'h2);
        tick(1);
        chk("pu_ch_rst_1048", 32'(ch_rst), 32'h0);
        chk("pu_ready_1048", 32'(all_ready), 32'h0);
        tick(1);
        chk("pu_ready_1049", 32'(all_ready), 32'h1);
        chk("pu_pll_rst_1049", 32'(pll_rst), 32'h0);
        chk("pu_loss_1049", 32'(lock_loss_cnt), 32'h0);

        // Lock loss in RUN.
        tick(5);
        locked_in = 2'b10;
        tick(2);
        chk("run_ready_sync", 32'(all_ready), 32'h1);
        chk("run_ch_rst_sync", 32'(ch_rst), 32'h0);
        tick(1);
        chk("run_loss_ch_rst", 32'(ch_rst), 32'h3);
        chk("run_loss_ready", 32'(all_ready), 32'h0);
        chk("run_loss_pll_rst", 32'(pll_rst), 32'h1);
        chk("run_loss_cnt", 32'(lock_loss_cnt), 32'h1);
        locked_in = 2'b11;
        tick(15);
        chk("run_pll_rst_15", 32'(pll_rst), 32'h1);
        tick(1);
        chk("run_pll_rst_16", 32'(pll_rst), 32'h0);

        // Glitch on locked_in[1] in WAIT_LOCK restarts the stable count.
        tick(100);
        locked_in = 2'b01;
        tick(3);
        locked_in = 2'b11;
        tick(921);
        chk("glitch_no_early_release", 32'(ch_rst), 32'h3);
        tick(104);
        chk("glitch_ch_rst_pre", 32'(ch_rst), 32'h3);
        tick(1);
        chk("glitch_release", 32'(ch_rst), 32'h2);
        chk("glitch_loss_cnt", 32'(lock_loss_cnt), 32'h1);

        // Lock loss between the two channel releases.
        locked_in = 2'b10;
        tick(2);
        chk("rel_ch_rst_sync", 32'(ch_rst), 32'h2);
        tick(1);
        chk("rel_loss_ch_rst", 32'(ch_rst), 32'h3);
        chk("rel_loss_pll_rst", 32'(pll_rst), 32'h1);
        chk("rel_loss_cnt", 32'(lock_loss_cnt), 32'h2);
        locked_in = 2'b11;
        tick(5);
        chk("rel_ch1_held", 32'(ch_rst), 32'h3);
        chk("rel_pll_rst_held", 32'(pll_rst), 32'h1);
        tick(11);
        chk("rel_pll_rst_low", 32'(pll_rst), 32'h0);
        tick(1024);
        chk("rel_release0", 32'(ch_rst), 32'h2);

        // Asynchronous reset mid-RELEASE, between edges.
        tick(3);
        chk("arst_pre_ch_rst", 32'(ch_rst), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pll_rst", 32'(pll_rst), 32'h1);
        chk("arst_ch_rst", 32'(ch_rst), 32'h3);
        chk("arst_ready", 32'(all_ready), 32'h0);
        chk("arst_loss_cnt", 32'(lock_loss_cnt), 32'h0);
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        tick(16);
        chk("arst_pll_rst_low", 32'(pll_rst), 32'h0);
        tick(1024);
        chk("arst_release0", 32'(ch_rst), 32'h2);
        tick(8);
        chk("arst_release1", 32'(ch_rst), 32'h0);
        tick(1);
        chk("arst_ready_run", 32'(all_ready), 32'h1);

        // Five losses saturate a 2-bit counter at 3.
        lose_and_relock(32'h1);
        lose_and_relock(32'h2);
        lose_and_relock(32'h3);
        lose_and_relock(32'h3);
        lose_and_relock(32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
